// File: rtl/con_port_seq_pkg.sv
// Shared constants and state encoding for the data-memory console port sequencer.
package con_port_seq_pkg;

    localparam int unsigned DATAMEM_BITS = 10;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned CPS_ADDR_W   = DATAMEM_BITS + 1;
    localparam int unsigned CPS_WORD_W   = WORD_WIDTH;

    localparam logic       OP_DUMP    = 1'b0;
    localparam logic       OP_LOAD    = 1'b1;
    localparam logic [3:0] CON_WE_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_D_ISSUE = 3'd2,
        ST_D_WAIT  = 3'd3,
        ST_D_HOLD  = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

endpackage

// File: rtl/con_port_seq.sv
// Console port sequencer: streams LOAD words into DATAMEM or DUMPs words out
// through a valid/ready handshake, one command at a time.
module con_port_seq
    import con_port_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = CPS_ADDR_W,
    parameter int unsigned WORD_W = CPS_WORD_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic [3:0]        con_write,
    output logic [ADDR_W-1:0] con_addr,
    output logic [WORD_W-1:0] con_in,
    input  logic [WORD_W-1:0] con_out
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     rem_q;
    logic [1:0]          wait_q;
    logic [ADDR_W-1:0]   con_addr_q;
    logic                cmd_fire, wr_fire, rd_fire, last_word;

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_ready && (state_q == ST_D_HOLD);
    assign last_word = (rem_q == (ADDR_W+1)'(1));

    // Console writes are combinational so each LOAD handshake writes in its own cycle.
    assign con_write = wr_fire ? CON_WE_ALL : 4'h0;
    assign con_in    = wr_fire ? wr_data : '0;
    assign con_addr  = (wr_fire || state_q == ST_D_ISSUE) ? ptr_q : con_addr_q;

    always_ff @(posedge CLK) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_count == '0)      state_d = ST_FIN;
                    else if (cmd_op == OP_LOAD) state_d = ST_LOAD;
                    else                        state_d = ST_D_ISSUE;
                end
            end
            ST_LOAD:    if (wr_fire && last_word) state_d = ST_FIN;
            ST_D_ISSUE: state_d = ST_D_WAIT;
            ST_D_WAIT:  if (wait_q == 2'd0) state_d = ST_D_HOLD;
            ST_D_HOLD:  if (rd_fire) state_d = last_word ? ST_FIN : ST_D_ISSUE;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pointer/remaining count, read-latency counter and DUMP output register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            ptr_q      <= '0;
            rem_q      <= '0;
            wait_q     <= 2'd0;
            con_addr_q <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_addr    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        ptr_q <= cmd_base;
                        rem_q <= cmd_count;
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        con_addr_q <= ptr_q;
                        ptr_q      <= ptr_q + ADDR_W'(1);
                        rem_q      <= rem_q - (ADDR_W+1)'(1);
                    end
                end
                ST_D_ISSUE: begin
                    con_addr_q <= ptr_q;
                    wait_q     <= 2'(RD_LAT - 1);
                end
                ST_D_WAIT: begin
                    if (wait_q == 2'd0) begin
                        rd_data  <= con_out;
                        rd_addr  <= ptr_q;
                        rd_valid <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                ST_D_HOLD: begin
                    if (rd_fire) begin
                        rd_valid <= 1'b0;
                        ptr_q    <= ptr_q + ADDR_W'(1);
                        rem_q    <= rem_q - (ADDR_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
